pmem_reader: RTL and testbench
==============================

# pmem_reader

Read-back engine for the psum memory (pmem) of one `fullchip` core. After a `start` pulse it drives the pmem read half of the core instruction word (`pmem_rd`, `pmem_add`) and captures each `col*bw_psum`-wide pmem row. It then streams the row one column at a time over a valid/ready port to the normalization/softmax stage or to the host bridge. It is the consumer of the ofifo→pmem write sequence: the writer fills rows `0..rows-1`, and this block drains them.

## Interface
- `bw`, 4, Q/K element width
- `pr`, 8, products per dot product
- `col`, 8, columns per core (psum words per pmem row)
- `bw_psum`, `2*bw+$clog2(pr)` = 11, psum word width
- `rows`, 8, rows read per `start`
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base_add`  in  4  first pmem address; sampled with `start`
- `pmem_rd`  out  1  maps to core inst[1]
- `pmem_add`  out  4  maps to core inst[11:8]
- `pmem_out`  in  col*bw_psum  pmem read data; column c is bits `[c*bw_psum +: bw_psum]`
- `out_data`  out  bw_psum+$clog2(col)  psum word, sign-extended two's complement
- `out_valid`  out  1  `out_data` beat valid
- `out_ready`  in  1  downstream accepts the beat when high with `out_valid`
- `out_col`  out  $clog2(col)  column index of the current beat
- `out_row`  out  4  pmem address of the current beat
- `out_last`  out  1  final beat of the final row
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the final beat is accepted

## Operation
- FSM states: IDLE → READ → WAIT → SEND → (READ or FIN) → IDLE.
- IDLE:
  - `start`=1 latches `add_r=base_add` and sets `row_cnt=0`.
  - The FSM moves to READ.
- READ:
  - `pmem_rd=1`, `pmem_add=add_r`, held for exactly one cycle.
  - The FSM moves to WAIT.
- WAIT:
  - `pmem_rd=0`.
  - At the end of the cycle, `pmem_out` is captured into `row_buf` and `col_cnt` is set to 0.
  - The FSM moves to SEND.
- SEND:
  - `out_valid=1`.
  - `out_data` = `row_buf[col_cnt*bw_psum +: bw_psum]`, sign-extended.
  - `out_col=col_cnt`, `out_row=add_r`.
  - On handshake (`out_valid & out_ready`): if `col_cnt<col-1`, increment `col_cnt`.
  - Otherwise the row is done: increment `add_r` (4-bit wrap, 15→0) and `row_cnt`. Go to FIN if `row_cnt==rows-1`, else go to READ.
- FIN: `done=1` for one cycle, then IDLE.
- `out_last` = SEND & `row_cnt==rows-1` & `col_cnt==col-1`.
- `start` outside IDLE is ignored; there is no queuing.
- `pmem_out` is sampled only at the end of WAIT and ignored in every other state.
- A `pmem_wr` issued by the ofifo mover during a read session is a system-level error. This block does not detect it.

## Timing
- Reset values: `pmem_rd=0`, `pmem_add=0`, `out_valid=0`, `out_data=0`, `out_col=0`, `out_row=0`, `out_last=0`, `busy=0`, `done=0`. FSM is in IDLE.
- `reset` asserted mid-session aborts immediately (asynchronously): all outputs return to reset values and the in-flight beat is dropped.
- Outputs are registered, except `out_last`, which is decoded from registered state.
- Edge E0 samples `start`.
- After E0: `pmem_rd` high.
- After E1: WAIT.
- After E2: first `out_valid`.
- pmem latency: data is valid in the cycle after `pmem_rd` is sampled.
- While `out_valid=1` and `out_ready=0`: `out_data`, `out_col`, `out_row` and `out_last` are held stable.
- `out_valid` never drops without a handshake.
- Throughput with `out_ready` tied high: `col+2` cycles per row. `busy` spans `rows*(col+2)+1` cycles.
- `done` pulses in the cycle after the final handshake. `busy` falls one cycle later.

## Configuration
- `PMEM_READER_ROWSUM_EN` defined:
  - After column `col-1` of each row, SEND issues one extra beat.
  - This beat carries the signed sum of all `col` words of the row, accumulated at width `bw_psum+$clog2(col)`. No overflow is possible at this width.
  - For the extra beat, `out_col` holds all-ones and `out_last` moves onto it for the final row.
  - Throughput becomes `col+3` cycles per row.
- Undefined: no sum beat and no adder logic. Behaviour is exactly as described in Operation and Timing.

## Test plan
- **Single row, ready tied high.** Preload pmem row 0 with columns 0..7 = 1,2,…,8; `rows=1`, `base_add=0`, pulse `start`.
  - `pmem_rd` is high for 1 cycle with `pmem_add=0`.
  - Beats 1..8 arrive on consecutive cycles starting at E2.
  - `out_last` is set on the 8th beat and `done` pulses on the next cycle.
- **Negative sign extension.** Column 3 = 11'h7FF (−1) → `out_data`=14'h3FFF. Column 5 = 11'h400 (−1024) → 14'h3C00.
- **Backpressure.** Toggle `out_ready` 1,0,0,1 repeatedly. The beat sequence must be unchanged, with no duplicate or missing beat and data held stable while `out_ready=0`. With `rows=8`, there are 64 beats total and `out_row` runs 0..7.
- **Address wrap and ignored start.** `base_add=14`, `rows=4` → `pmem_add` sequence 14,15,0,1. A second `start` mid-session produces no extra `pmem_rd`.
- **Reset mid-session.** Assert `reset` during row 2, column 4.
  - All outputs go to 0 within the reset cycle.
  - After release, a fresh `start` reads from the new `base_add`.
- **`PMEM_READER_ROWSUM_EN`.** Row = 100,−5,3,0,0,0,0,7.
  - A 9th beat carries 105 with `out_col`=7'b… (all-ones 3'b111) and `out_last` set.
  - A row of 8×1023 sums to 8184 without overflow.

Source files
------------

// File: rtl/pmem_reader_if.sv
// ---------------------------------------------------------------------------
// pmem_reader_if
//
// Bundles the two buses of the pmem read-back engine:
//   - pmem read half of the core instruction word plus the returned row
//       pmem_rd   : read strobe (core inst[1])
//       pmem_add  : row address (core inst[11:8])
//       pmem_out  : COL*BW_PSUM-bit row, column c at [c*BW_PSUM +: BW_PSUM]
//   - valid/ready beat stream towards normalization/softmax or host bridge
//       out_data  : sign-extended psum word (or row sum)
//       out_valid : beat valid
//       out_ready : downstream accepts the beat
//       out_col   : column index of the beat
//       out_row   : pmem address of the beat
//       out_last  : final beat of the final row
//
// Modports:
//   master : the reader (drives pmem request and stream)
//   slave  : pmem + downstream side (drives pmem_out and out_ready)
// ---------------------------------------------------------------------------
interface pmem_reader_if #(
    parameter int BW_PSUM = 11,
    parameter int COL     = 8,
    parameter int AW      = 4
);
    localparam int CW = $clog2(COL);
    localparam int OW = BW_PSUM + CW;

    logic                   pmem_rd;
    logic [AW-1:0]          pmem_add;
    logic [COL*BW_PSUM-1:0] pmem_out;
    logic [OW-1:0]          out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [CW-1:0]          out_col;
    logic [AW-1:0]          out_row;
    logic                   out_last;

    modport master (
        output pmem_rd, pmem_add,
        input  pmem_out,
        output out_data, out_valid,
        input  out_ready,
        output out_col, out_row, out_last
    );

    modport slave (
        input  pmem_rd, pmem_add,
        output pmem_out,
        input  out_data, out_valid,
        output out_ready,
        input  out_col, out_row, out_last
    );
endinterface

// File: rtl/pmem_reader.sv
// ---------------------------------------------------------------------------
// pmem_reader
//
// Read-back engine for the psum memory of one fullchip core. A start pulse
// reads ROWS consecutive pmem rows (4-bit address wrap) beginning at
// i_base_add; each row is captured whole and streamed one column per beat.
//
// Ports:
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-high reset
//   i_start    : one-cycle request, honoured only when idle
//   i_base_add : first pmem address, sampled with i_start
//   bus        : pmem_reader_if.master (pmem request/data + beat stream)
//   o_busy     : high whenever the engine is not idle
//   o_done     : one-cycle pulse after the final beat is accepted
//
// Optional feature (macro PMEM_READER_ROWSUM_EN):
//   each row is followed by one extra beat carrying the signed sum of its
//   COL words, out_col all-ones; out_last moves onto that beat.
// ---------------------------------------------------------------------------
module pmem_reader #(
    parameter int BW   = 4,
    parameter int PR   = 8,
    parameter int COL  = 8,
    parameter int ROWS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [3:0]           i_base_add,
    pmem_reader_if.master        bus,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int BW_PSUM = 2*BW + $clog2(PR);
    localparam int CW      = $clog2(COL);
    localparam int OW      = BW_PSUM + CW;
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ROW_W   = COL * BW_PSUM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_FIN
    } state_t;

    state_t           r_state;
    logic [3:0]       r_add;
    logic [RW-1:0]    r_row_cnt;
    logic [CW-1:0]    r_col_cnt;
    logic [ROW_W-1:0] r_row_buf;
    logic             r_pmem_rd;
    logic [3:0]       r_pmem_add;
    logic             r_out_valid;
    logic [OW-1:0]    r_out_data;
    logic             r_busy;
    logic             r_done;
`ifdef PMEM_READER_ROWSUM_EN
    logic             r_sum_beat;   // current beat is the row-sum beat
`endif

    logic          w_last_row;
    logic          w_last_col;
    logic          w_hs;
    logic [CW-1:0] w_col_next;

    assign w_last_row = (r_row_cnt == RW'(ROWS - 1));
    assign w_last_col = (r_col_cnt == CW'(COL - 1));
    assign w_hs       = r_out_valid & bus.out_ready;
    assign w_col_next = r_col_cnt + CW'(1);

    function automatic logic [OW-1:0] sext(input logic [BW_PSUM-1:0] w);
        return {{CW{w[BW_PSUM-1]}}, w};
    endfunction

    function automatic logic [BW_PSUM-1:0] col_word(input logic [ROW_W-1:0] row,
                                                    input logic [CW-1:0]    idx);
        return row[int'(idx)*BW_PSUM +: BW_PSUM];
    endfunction

`ifdef PMEM_READER_ROWSUM_EN
    // OW = BW_PSUM + log2(COL) bits hold the sum of COL words without overflow.
    function automatic logic [OW-1:0] row_sum(input logic [ROW_W-1:0] row);
        logic [OW-1:0] acc;
        acc = '0;
        for (int c = 0; c < COL; c++) begin
            acc = acc + sext(row[c*BW_PSUM +: BW_PSUM]);
        end
        return acc;
    endfunction
`endif

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_add       <= '0;
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            // NOTE: the row buffer is always rewritten before use; it is
            // cleared here only so no X leaks out of it after reset.
            r_row_buf   <= '0;
            r_pmem_rd   <= 1'b0;
            r_pmem_add  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef PMEM_READER_ROWSUM_EN
            r_sum_beat  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_add      <= i_base_add;
                        r_row_cnt  <= '0;
                        r_pmem_rd  <= 1'b1;
                        r_pmem_add <= i_base_add;
                        r_busy     <= 1'b1;
                        r_state    <= S_READ;
                    end
                end

                S_READ: begin
                    r_pmem_rd <= 1'b0;
                    r_state   <= S_WAIT;
                end

                S_WAIT: begin
                    // pmem answers one cycle after the strobe, i.e. now.
                    // Column 0 goes straight from the bus to the output register.
                    r_row_buf   <= bus.pmem_out;
                    r_col_cnt   <= '0;
                    r_out_valid <= 1'b1;
                    r_out_data  <= sext(col_word(bus.pmem_out, '0));
`ifdef PMEM_READER_ROWSUM_EN
                    r_sum_beat  <= 1'b0;
`endif
                    r_state     <= S_SEND;
                end

                S_SEND: begin
                    if (w_hs) begin
                        if (!w_last_col) begin
                            r_col_cnt  <= w_col_next;
                            r_out_data <= sext(col_word(r_row_buf, w_col_next));
                        end
`ifdef PMEM_READER_ROWSUM_EN
                        else if (!r_sum_beat) begin
                            r_sum_beat <= 1'b1;
                            r_col_cnt  <= '1;
                            r_out_data <= row_sum(r_row_buf);
                        end
`endif
                        else begin
                            r_out_valid <= 1'b0;
                            r_add       <= r_add + 4'd1;
                            r_row_cnt   <= r_row_cnt + RW'(1);
                            if (w_last_row) begin
                                r_done  <= 1'b1;
                                r_state <= S_FIN;
                            end else begin
                                r_pmem_rd  <= 1'b1;
                                r_pmem_add <= r_add + 4'd1;
                                r_state    <= S_READ;
                            end
                        end
                    end
                end

                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pmem_rd   = r_pmem_rd;
    assign bus.pmem_add  = r_pmem_add;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_col   = r_col_cnt;
    assign bus.out_row   = r_add;
`ifdef PMEM_READER_ROWSUM_EN
    assign bus.out_last  = (r_state == S_SEND) & w_last_row & r_sum_beat;
`else
    assign bus.out_last  = (r_state == S_SEND) & w_last_row & w_last_col;
`endif
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_pmem_reader.sv
// ---------------------------------------------------------------------------
// tb_pmem_reader
//
// Drives pmem_reader against a 16-row pmem model and checks every beat,
// the pmem read address sequence, done/busy timing and reset behaviour
// against a reference beat list built from the row contents.
// ---------------------------------------------------------------------------
module tb_pmem_reader;
    localparam int COL  = 8;
    localparam int ROWS = 8;
    localparam int BWP  = 11;
`ifdef PMEM_READER_ROWSUM_EN
    localparam int SUM  = 1;
`else
    localparam int SUM  = 0;
`endif

    logic       clk;
    logic       reset;
    logic       i_start;
    logic [3:0] i_base_add;
    logic       o_busy;
    logic       o_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [COL*BWP-1:0] mem [16];
    logic [95:0]        noise;

    pmem_reader_if #(.BW_PSUM(BWP), .COL(COL)) bus ();

    pmem_reader #(.BW(4), .PR(8), .COL(COL), .ROWS(ROWS)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_base_add (i_base_add),
        .bus        (bus.master),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pmem model: data valid only in the cycle after the strobe, noise otherwise.
    always @(posedge clk) begin
        noise = {$urandom, $urandom, $urandom};
        if (bus.pmem_rd) bus.pmem_out <= mem[bus.pmem_add];
        else             bus.pmem_out <= noise[COL*BWP-1:0];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int word_val(input logic [COL*BWP-1:0] row, input int c);
        logic [BWP-1:0] w;
        w = row[c*BWP +: BWP];
        return w[BWP-1] ? int'(w) - 2048 : int'(w);
    endfunction

    function automatic logic [21:0] pack_beat(input int d, input int c, input logic [3:0] r, input bit l);
        logic [13:0] dd;
        logic [2:0]  cc;
        dd = 14'(d);
        cc = 3'(c);
        return {dd, cc, r, l};
    endfunction

    function automatic logic [21:0] dut_beat();
        return {bus.out_data, bus.out_col, bus.out_row, bus.out_last};
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({bus.pmem_rd, bus.pmem_add, bus.out_valid, bus.out_data, bus.out_col,
                    bus.out_row, bus.out_last, o_busy, o_done});
    endfunction

    // One session; entered and left just after a rising edge.
    // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic run_session(input logic [3:0] base, input int mode, input bit extra_start);
        logic [21:0] exp_q[$];
        logic [3:0]  exp_add[$];
        logic [3:0]  got_add[$];
        logic [3:0]  a;
        int          sum, v;
        int          first_v, last_hs, done_t, done_n, busy_n, busy_low;
        bit          rdy;

        for (int r = 0; r < ROWS; r++) begin
            a = 4'(int'(base) + r);
            exp_add.push_back(a);
            sum = 0;
            for (int c = 0; c < COL; c++) begin
                v = word_val(mem[a], c);
                sum += v;
                exp_q.push_back(pack_beat(v, c, a, (r == ROWS-1) && (c == COL-1) && (SUM == 0)));
            end
            if (SUM != 0) exp_q.push_back(pack_beat(sum, COL-1, a, r == ROWS-1));
        end

        first_v = -1; last_hs = -1; done_t = -1; done_n = 0; busy_n = 0; busy_low = -1;
        i_base_add = base;
        i_start    = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("rd_after_E0", {bus.pmem_rd, bus.pmem_add}, {1'b1, base});

        for (int t = 0; t < 3000; t++) begin
            if (extra_start) begin
                i_start    = (t == 5);
                i_base_add = 4'(int'(base) + 7);
            end
            if (bus.pmem_rd) got_add.push_back(bus.pmem_add);
            if (!o_busy) begin
                busy_low = t;
                break;
            end
            busy_n++;
            if (o_done) begin
                done_n++;
                done_t = t;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (t % 4 == 0) || (t % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            if (bus.out_valid) begin
                if (first_v < 0) first_v = t;
                check("beat_expected", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check("beat", dut_beat(), exp_q[0]);
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) last_hs = t;
                    end
                end
            end
            @(posedge clk); #1;
        end
        i_start = 1'b0;
        bus.out_ready = 1'b0;

        check("beats_left", exp_q.size(), 0);
        check("first_valid_t", first_v, 2);
        check("done_count", done_n, 1);
        check("done_after_last", done_t, last_hs + 1);
        check("busy_fall", busy_low, done_t + 1);
        if (mode == 0) check("busy_span", busy_n, ROWS*(COL+2+SUM) + 1);
        check("rd_count", got_add.size(), ROWS);
        for (int i = 0; i < got_add.size() && i < ROWS; i++)
            check("rd_addr", got_add[i], exp_add[i]);
    endtask

    initial begin
        logic [95:0] tmp;
        int          rs[COL];
        bit          found;

        reset         = 1'b1;
        i_start       = 1'b0;
        i_base_add    = 4'd0;
        bus.out_ready = 1'b0;

        for (int i = 0; i < 16; i++) begin
            tmp    = {$urandom, $urandom, $urandom};
            mem[i] = tmp[COL*BWP-1:0];
        end
        // row 0: 1..8; row 1: -1 and -1024 in columns 3 and 5;
        // row 2: 100,-5,3,0,0,0,0,7; row 3: all 1023
        rs = '{100, -5, 3, 0, 0, 0, 0, 7};
        for (int c = 0; c < COL; c++) begin
            mem[0][c*BWP +: BWP] = BWP'(c + 1);
            mem[2][c*BWP +: BWP] = BWP'(rs[c]);
            mem[3][c*BWP +: BWP] = 11'd1023;
        end
        mem[1][3*BWP +: BWP] = 11'h7FF;
        mem[1][5*BWP +: BWP] = 11'h400;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_outputs", all_outs(), 0);

        // ready high from row 0 (directed rows 0..3 then random rows)
        run_session(4'd0, 0, 1'b0);
        // backpressure, address wrap and ignored second start
        run_session(4'd14, 1, 1'b1);
        // random backpressure from a random base
        run_session(4'($urandom_range(0, 15)), 2, 1'b0);

        // reset during row 2, column 4
        i_base_add = 4'd3;
        i_start    = 1'b1;
        @(posedge clk); #1;
        i_start       = 1'b0;
        bus.out_ready = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (bus.out_valid && bus.out_row == 4'd5 && bus.out_col == 3'd4) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("reset_point_found", 64'(found), 1);
        reset = 1'b1;
        #1;
        check("outputs_in_reset", all_outs(), 0);
        bus.out_ready = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", all_outs(), 0);
        run_session(4'd10, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
